pyjamask96_stream_ctrl: RTL and testbench

//  Upstream/downstream controller for the byte-serial pyjamask96 core. Takes one 96-bit plaintext and
//  one 128-bit key over a valid/ready handshake, then drives the core's load/start byte protocol.

---
 rtl/pyjamask96_stream_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_pyjamask96_stream_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pyjamask96_stream_ctrl.sv
// Block-level wrapper around the byte-serial pyjamask96 core: loads one plaintext/key pair,
// starts the core, gathers the 12 ciphertext bytes and hands back one 96-bit word.
module pyjamask96_stream_ctrl #(
    parameter int START_CYCLES = 2,
    parameter int GAP_CYCLES   = 1,
    parameter int TIMEOUT      = 4096
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [95:0]  pt_in,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [95:0]  ct_out,
    output logic         busy,
    output logic         err,
    output logic         core_load,
    output logic         core_start,
    output logic [7:0]   core_byte_in,
    output logic [7:0]   core_byte_key_in,
    input  logic         core_valid,
    input  logic [7:0]   core_byte_out
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid is never withdrawn by this block once raised, and ready never depends on valid.

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int CW = 8;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_GAP, S_START, S_WAIT, S_COLLECT, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [95:0]    pt_q, pt_d;
    logic [127:0]   key_q, key_d;
    logic [95:0]    ct_q, ct_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic           busy_q, busy_d;
    logic           err_q, err_d;
    logic           load_q, load_d;
    logic           start_q, start_d;
    logic [7:0]     byte_in_q, byte_in_d;
    logic [7:0]     byte_key_q, byte_key_d;

    // Byte i counted from the MSB end; indices past the end shift out to zero, which
    // gives the 00 padding on core_byte_in for load indices 12..15 for free.
    function automatic logic [7:0] pt_byte(input logic [95:0] v, input logic [3:0] i);
        logic [95:0] s;
        s = v << {i, 3'b000};
        return s[95:88];
    endfunction

    function automatic logic [7:0] key_byte(input logic [127:0] v, input logic [3:0] i);
        logic [127:0] s;
        s = v << {i, 3'b000};
        return s[127:120];
    endfunction

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        pt_d        = pt_q;
        key_d       = key_q;
        ct_d        = ct_q;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        err_d       = 1'b0;
        load_d      = 1'b0;
        start_d     = 1'b0;
        byte_in_d   = 8'h00;
        byte_key_d  = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    pt_d       = pt_in;
                    key_d      = key_in;
                    idx_d      = 4'd0;
                    state_d    = S_LOAD;
                    load_d     = 1'b1;
                    byte_in_d  = pt_byte(pt_in, 4'd0);
                    byte_key_d = key_byte(key_in, 4'd0);
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            S_LOAD: begin
                if (idx_q == 4'd15) begin
                    cnt_d = '0;
                    if (GAP_CYCLES == 0) begin
                        state_d = S_START;
                        start_d = 1'b1;
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    idx_d      = idx_q + 4'd1;
                    load_d     = 1'b1;
                    byte_in_d  = pt_byte(pt_q, idx_q + 4'd1);
                    byte_key_d = key_byte(key_q, idx_q + 4'd1);
                end
            end
            S_GAP: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    state_d = S_START;
                    start_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_START: begin
                if (cnt_q == CW'(START_CYCLES - 1)) begin
                    state_d = S_WAIT;
                    timer_d = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    start_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (core_valid) begin
                    ct_d    = {ct_q[87:0], core_byte_out};
                    cnt_d   = CW'(1);
                    state_d = S_COLLECT;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    err_d      = 1'b1;
                    state_d    = S_IDLE;
                    in_ready_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_COLLECT: begin
                // Cycles without core_valid are simply skipped; the core may stall mid-stream.
                if (core_valid) begin
                    ct_d  = {ct_q[87:0], core_byte_out};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(11)) begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d    = S_IDLE;
                    in_ready_d = 1'b1;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            timer_q     <= '0;
            pt_q        <= '0;
            key_q       <= '0;
            ct_q        <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            load_q      <= 1'b0;
            start_q     <= 1'b0;
            byte_in_q   <= 8'h00;
            byte_key_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            timer_q     <= timer_d;
            pt_q        <= pt_d;
            key_q       <= key_d;
            ct_q        <= ct_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            load_q      <= load_d;
            start_q     <= start_d;
            byte_in_q   <= byte_in_d;
            byte_key_q  <= byte_key_d;
        end
    end

    assign in_ready         = in_ready_q;
    assign out_valid        = out_valid_q;
    assign ct_out           = ct_q;
    assign busy             = busy_q;
    assign err              = err_q;
    assign core_load        = load_q;
    assign core_start       = start_q;
    assign core_byte_in     = byte_in_q;
    assign core_byte_key_in = byte_key_q;

endmodule

// File: tb/tb_pyjamask96_stream_ctrl.sv
// Randomized bench for pyjamask96_stream_ctrl: a behavioural core model answers the load/start
// protocol, and a scoreboard checks every ciphertext word the controller hands out.
module tb_pyjamask96_stream_ctrl;

    localparam int TIMEOUT = 16;
    localparam logic [127:0] VEC_KEY = 128'h00112233445566778899aabbccddeeff;
    localparam logic [95:0]  VEC_PT  = 96'h50796a616d61736b39363a29;
    localparam logic [95:0]  VEC_CT  = 96'hca9c6e1abbde4edc27073da6;
    localparam logic [95:0]  SEQ_CT  = 96'h0102030405060708090a0b0c;

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [95:0]  pt_in;
    logic [127:0] key_in;
    logic         out_valid;
    logic         out_ready;
    logic [95:0]  ct_out;
    logic         busy;
    logic         err;
    logic         core_load;
    logic         core_start;
    logic [7:0]   core_byte_in;
    logic [7:0]   core_byte_key_in;
    logic         core_valid;
    logic [7:0]   core_byte_out;

    int n_vec = 0;
    int n_err = 0;
    logic [95:0]  exp_q[$];
    logic [223:0] ld_q[$];
    int core_mode = 0;   // 0: normal with random stalls, 1: never answers, 2: bytes 01..0c with a stall
    int rdy_mode  = 0;   // 0: random out_ready, 1: held low, 2: held high

    pyjamask96_stream_ctrl #(
        .START_CYCLES(2),
        .GAP_CYCLES  (1),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .pt_in           (pt_in),
        .key_in          (key_in),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .ct_out          (ct_out),
        .busy            (busy),
        .err             (err),
        .core_load       (core_load),
        .core_start      (core_start),
        .core_byte_in    (core_byte_in),
        .core_byte_key_in(core_byte_key_in),
        .core_valid      (core_valid),
        .core_byte_out   (core_byte_out)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500000ns");
        $fatal(1);
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got bound expired, expected event", name);
    endtask

    // Reference: the fake core's output for any pair other than the published vector.
    function automatic logic [95:0] ref_ct(input logic [95:0] pt, input logic [127:0] key);
        logic [95:0] r;
        for (int i = 0; i < 12; i++)
            r[95-8*i -: 8] = pt[95-8*i -: 8] ^ key[127-8*i -: 8] ^ key[31-8*(i%4) -: 8] ^ 8'(i*37);
        return r;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check(tag, 128'({in_ready, out_valid, busy, err, core_load, core_start,
                         core_byte_in, core_byte_key_in}), 128'd0);
        check({tag, "_ct"}, 128'(ct_out), 128'd0);
    endtask

    // ---------------- core model ----------------
    logic [7:0] ld_pt[16];
    logic [7:0] ld_key[16];

    task automatic core_serve();
        int n, gap, s, d;
        logic [223:0] want;
        logic [127:0] got_pt, got_key;
        logic [95:0]  v;
        logic [7:0]   ctb[12];
        want = '0;
        if (ld_q.size() > 0) want = ld_q.pop_front();
        else fail_now("core_unexpected_load");
        n = 0;
        while (core_load && reset_n && n < 20) begin
            ld_pt[n%16]  = core_byte_in;
            ld_key[n%16] = core_byte_key_in;
            n++;
            @(negedge clk);
        end
        if (!reset_n) return;
        check("load_len", 128'(n), 128'd16);
        got_pt  = '0;
        got_key = '0;
        for (int i = 0; i < 16; i++) begin
            got_pt  = {got_pt[119:0], ld_pt[i]};
            got_key = {got_key[119:0], ld_key[i]};
        end
        check("load_pt_bytes", got_pt, {want[223:128], 32'h0});
        check("load_key_bytes", got_key, want[127:0]);
        gap = 0;
        while (!core_start && reset_n && gap < 10) begin
            gap++;
            @(negedge clk);
        end
        check("gap_len", 128'(gap), 128'd1);
        s = 0;
        while (core_start && reset_n && s < 10) begin
            s++;
            @(negedge clk);
        end
        check("start_len", 128'(s), 128'd2);
        if (!reset_n || core_mode == 1) return;

        v = VEC_CT;
        for (int i = 0; i < 12; i++) begin
            if (want == {VEC_PT, VEC_KEY}) ctb[i] = v[95-8*i -: 8];
            else if (core_mode == 2)       ctb[i] = 8'(i + 1);
            else ctb[i] = ld_pt[i] ^ ld_key[i] ^ ld_key[12+i%4] ^ ld_pt[12+i%4] ^ 8'(i*37);
        end
        d = $urandom_range(0, 8);
        repeat (d) begin
            core_byte_out = 8'($urandom);
            @(negedge clk);
        end
        for (int i = 0; i < 12; i++) begin
            if (core_mode == 2 && i == 5) begin
                core_valid = 1'b0;
                core_byte_out = 8'($urandom);
                repeat (3) @(negedge clk);
            end else if (core_mode == 0 && i > 0 && $urandom_range(0, 3) == 0) begin
                core_valid = 1'b0;
                core_byte_out = 8'($urandom);
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
            core_valid    = 1'b1;
            core_byte_out = ctb[i];
            @(negedge clk);
        end
        core_valid    = 1'b0;
        core_byte_out = 8'h00;
    endtask

    initial begin
        core_valid    = 1'b0;
        core_byte_out = 8'h00;
        forever begin
            @(negedge clk);
            if (reset_n && core_load) core_serve();
        end
    end

    // ---------------- consumer ----------------
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       out_ready = 1'b0;
                2:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [95:0] e;
        forever begin
            @(negedge clk);
            if (reset_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL ct_out_unexpected: got %h expected no output", ct_out);
                end else begin
                    e = exp_q.pop_front();
                    check("ct_out", 128'(ct_out), 128'(e));
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic [95:0] pt, input logic [127:0] key,
                        input logic [95:0] exp, input bit expect_out);
        int k;
        k = 0;
        in_valid = 1'b1;
        pt_in    = pt;
        key_in   = key;
        while (!in_ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            fail_now("accept_timeout");
            in_valid = 1'b0;
            return;
        end
        ld_q.push_back({pt, key});
        if (expect_out) exp_q.push_back(exp);
        @(negedge clk);
        in_valid = 1'b0;
        pt_in    = {$urandom, $urandom, $urandom};
        key_in   = {$urandom, $urandom, $urandom, $urandom};
        check("load_latency", 128'(core_load), 128'd1);
        check("busy_high", 128'(busy), 128'd1);
        check("in_ready_low", 128'(in_ready), 128'd0);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 600) begin
            @(negedge clk);
            k++;
        end
        if (k >= 600) fail_now("drain_timeout");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int k;
        bit saw_ov;
        logic [95:0]  rpt;
        logic [127:0] rkey;

        reset_n  = 1'b0;
        in_valid = 1'b0;
        pt_in    = '0;
        key_in   = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_outputs");
        reset_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", 128'(in_ready), 128'd1);
        check("busy_after_reset", 128'(busy), 128'd0);

        // Known vector, with load/gap/start protocol checked by the core model
        send(VEC_PT, VEC_KEY, VEC_CT, 1'b1);
        drain();

        // Back-pressure on the output
        rdy_mode = 1;
        send(VEC_PT, VEC_KEY, VEC_CT, 1'b1);
        k = 0;
        while (!out_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!out_valid) fail_now("bp_out_valid_timeout");
        repeat (20) begin
            @(negedge clk);
            check("bp_out_valid", 128'(out_valid), 128'd1);
            check("bp_ct_stable", 128'(ct_out), 128'(VEC_CT));
            check("bp_in_ready", 128'(in_ready), 128'd0);
        end
        rdy_mode = 2;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_in_ready", 128'(in_ready), 128'd1);
        check("bp_release_out_valid", 128'(out_valid), 128'd0);
        rdy_mode = 0;

        // Core never answers: abort after TIMEOUT cycles in WAIT
        core_mode = 1;
        send({$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, '0, 1'b0);
        k = 0;
        saw_ov = 1'b0;
        while (!err && k < 200) begin
            @(negedge clk);
            k++;
            if (out_valid) saw_ov = 1'b1;
        end
        // handshake edge T: WAIT spans T+20..T+35, err visible in cycle T+36
        check("timeout_err_delay", 128'(k), 128'd35);
        check("timeout_busy", 128'(busy), 128'd0);
        @(negedge clk);
        check("timeout_err_single", 128'(err), 128'd0);
        check("timeout_in_ready", 128'(in_ready), 128'd1);
        check("timeout_no_out_valid", 128'(saw_ov), 128'd0);

        // Stalled byte stream 01..0c
        core_mode = 2;
        send({$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, SEQ_CT, 1'b1);
        drain();
        core_mode = 0;

        // Reset in the middle of LOAD (index 7)
        send({$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, '0, 1'b0);
        repeat (7) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("midload_reset_outputs");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("midload_in_ready", 128'(in_ready), 128'd1);
        send(VEC_PT, VEC_KEY, VEC_CT, 1'b1);
        drain();

        // Random blocks, random output back-pressure and core stalls
        for (int b = 0; b < 25; b++) begin
            rpt  = {$urandom, $urandom, $urandom};
            rkey = {$urandom, $urandom, $urandom, $urandom};
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(rpt, rkey, ref_ct(rpt, rkey), 1'b1);
        end
        drain();
        check("exp_q_empty", 128'(exp_q.size()), 128'd0);
        check("ld_q_empty", 128'(ld_q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
